// File: rtl/inst_encoder_loader_pkg.sv
// Shared definitions for the instruction encoder/loader: format codes
// (same encoding as the decoder's imm_sel), opcode[6:2] values, the loader
// FSM state type and an immediate range helper.
// The helper is only used when ENC_RANGE_CHECK_EN is defined.
package inst_encoder_loader_pkg;

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_U = 3'b011;
  localparam logic [2:0] FMT_J = 3'b100;
  localparam logic [2:0] FMT_R = 3'b101;

  localparam logic [4:0] OP_R     = 5'b01100;
  localparam logic [4:0] OP_IMM   = 5'b00100;
  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;
  localparam logic [4:0] OP_BR    = 5'b11000;
  localparam logic [4:0] OP_LUI   = 5'b01101;
  localparam logic [4:0] OP_AUIPC = 5'b00101;
  localparam logic [4:0] OP_JAL   = 5'b11011;
  localparam logic [4:0] OP_JALR  = 5'b11001;

  // opcode[1:0] of every 32-bit RV32I instruction
  localparam logic [1:0] OPC_LOW = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READY = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // True when bits [31:msb] of imm are all equal, i.e. imm is a valid
  // sign-extended value of a (msb+1)-bit signed field.
  function automatic logic imm_fits(input logic [31:0] imm, input logic [4:0] msb);
    logic [31:0] hi_s;
    logic [31:0] ones_s;
    hi_s   = imm >> msb;
    ones_s = 32'hFFFF_FFFF >> msb;
    return (hi_s == 32'h0000_0000) || (hi_s == ones_s);
  endfunction

endpackage

// File: rtl/inst_encoder_loader_pack.sv
// inst_pack: purely combinational field-to-word packer for RV32I.
// Raises err for unknown formats and odd B/J offsets.
// Optional macro ENC_RANGE_CHECK_EN adds immediate range checks; without it
// out-of-range immediate bits are silently truncated.
module inst_pack
  import inst_encoder_loader_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [4:0]  op,
  input  logic [2:0]  funct3,
  input  logic        f7b5,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        err
);

  logic [6:0]  opc_s;
  logic [11:0] i_imm_s;
  logic        fmt_err_s;
  logic        align_err_s;
  logic        range_err_s;

  assign opc_s = {op, OPC_LOW};

  // Shift-immediates carry funct7 in the upper immediate bits
  always_comb begin
    i_imm_s = imm[11:0];
    if ((op == OP_IMM) && ((funct3 == 3'b001) || (funct3 == 3'b101))) begin
      i_imm_s = {1'b0, f7b5, 5'b00000, imm[4:0]};
    end else begin
      i_imm_s = imm[11:0];
    end
  end

  // Bit-field packing per format plus format/alignment checks
  always_comb begin
    word        = 32'h0000_0000;
    fmt_err_s   = 1'b0;
    align_err_s = 1'b0;
    case (fmt)
      FMT_R: word = {1'b0, f7b5, 5'b00000, rs2, rs1, funct3, rd, opc_s};
      FMT_I: word = {i_imm_s, rs1, funct3, rd, opc_s};
      FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opc_s};
      FMT_B: begin
        word        = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opc_s};
        align_err_s = imm[0];
      end
      FMT_U: word = {imm[31:12], rd, opc_s};
      FMT_J: begin
        word        = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc_s};
        align_err_s = imm[0];
      end
      default: begin
        word      = 32'h0000_0000;
        fmt_err_s = 1'b1;
      end
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // Immediate must be representable in the target field
  always_comb begin
    range_err_s = 1'b0;
    case (fmt)
      FMT_I, FMT_S: range_err_s = !imm_fits(imm, 5'd11);
      FMT_B:        range_err_s = !imm_fits(imm, 5'd12);
      FMT_J:        range_err_s = !imm_fits(imm, 5'd20);
      FMT_U:        range_err_s = (imm[11:0] != 12'h000);
      default:      range_err_s = 1'b0;
    endcase
  end
`else
  assign range_err_s = 1'b0;
`endif

  assign err = fmt_err_s | align_err_s | range_err_s;

endmodule

// File: rtl/inst_encoder_loader.sv
// inst_encoder_loader: packs decoded instruction fields into RV32I words and
// streams them to instruction memory at sequential word addresses using a
// write/acknowledge handshake. Optional macro ENC_RANGE_CHECK_EN (handled in
// inst_pack) adds immediate range checking.
module inst_encoder_loader
  import inst_encoder_loader_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int BASE  = 0,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_fmt,
  input  logic [4:0]    in_op,
  input  logic [2:0]    in_funct3,
  input  logic          in_f7b5,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [31:0]   in_imm,
  input  logic          in_last,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  input  logic          imem_ack,
  output logic [CW-1:0] count,
  output logic          done,
  output logic          err
);

  localparam logic [AW-1:0] BASE_ADDR = AW'(BASE);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          ready_q, ready_d;
  logic [CW-1:0] count_q, count_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          last_q, last_d;

  logic [31:0]   pack_word_s;
  logic          pack_err_s;

  inst_pack u_pack (
    .fmt    (in_fmt),
    .op     (in_op),
    .funct3 (in_funct3),
    .f7b5   (in_f7b5),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .imm    (in_imm),
    .word   (pack_word_s),
    .err    (pack_err_s)
  );

  // Next-state, pointer, counter and flag logic; start overrides everything
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    done_d  = done_q;
    err_d   = err_q;
    last_d  = last_q;
    if (start) begin
      state_d = ST_READY;
      addr_d  = BASE_ADDR;
      count_d = {CW{1'b0}};
      done_d  = 1'b0;
      err_d   = 1'b0;
      last_d  = 1'b0;
    end else begin
      case (state_q)
        ST_READY: begin
          if (in_valid && ready_q) begin
            if (pack_err_s) begin
              err_d = 1'b1;
            end else begin
              wdata_d = pack_word_s;
              last_d  = in_last;
              state_d = ST_WRITE;
            end
          end else begin
            state_d = ST_READY;
          end
        end
        ST_WRITE: begin
          if (imem_ack && we_q) begin
            addr_d  = (addr_q == LAST_ADDR) ? {AW{1'b0}} : (addr_q + ADDR_ONE);
            count_d = count_q + CNT_ONE;
            if (last_q) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_READY;
              // memory is full and the program has not ended: no wrap overwrite
              if (count_q == (DEPTH_CNT - CNT_ONE)) begin
                err_d = 1'b1;
              end else begin
                err_d = err_q;
              end
            end
          end else begin
            state_d = ST_WRITE;
          end
        end
        ST_IDLE: state_d = ST_IDLE;
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
    ready_d = (state_d == ST_READY) && !err_d && (count_d < DEPTH_CNT);
    we_d    = (state_d == ST_WRITE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= BASE_ADDR;
      wdata_q <= 32'h0000_0000;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      count_q <= {CW{1'b0}};
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      count_q <= count_d;
      done_q  <= done_d;
      err_q   <= err_d;
      last_q  <= last_d;
    end
  end

  assign in_ready   = ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Self-checking bench for inst_encoder_loader: a default instance (DEPTH=256)
// and a DEPTH=4 instance for overflow, sharing the field inputs.
module tb_inst_encoder_loader;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_f7b5, in_last;
  logic [2:0]  in_fmt, in_funct3;
  logic [4:0]  in_op, in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;

  logic        a_ready, a_we, a_done, a_err, a_ack, a_ack_drv, a_auto;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata;
  logic [8:0]  a_count;
  logic        b_ready, b_we, b_done, b_err, b_ack, b_ack_drv, b_auto;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  logic [2:0]  b_count;

  typedef struct { logic [7:0] addr; logic [31:0] data; } exp_t;
  exp_t sb[$];
  logic [7:0] exp_next_addr;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign a_ack = a_auto ? a_we : a_ack_drv;
  assign b_ack = b_auto ? b_we : b_ack_drv;

  inst_encoder_loader u_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(a_ready),
    .in_fmt(in_fmt), .in_op(in_op), .in_funct3(in_funct3), .in_f7b5(in_f7b5),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata), .imem_ack(a_ack),
    .count(a_count), .done(a_done), .err(a_err)
  );

  inst_encoder_loader #(.DEPTH(4), .BASE(0)) u_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(b_ready),
    .in_fmt(in_fmt), .in_op(in_op), .in_funct3(in_funct3), .in_f7b5(in_f7b5),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata), .imem_ack(b_ack),
    .count(b_count), .done(b_done), .err(b_err)
  );

  function automatic logic rdy_of(input bit sel);
    return sel ? b_ready : a_ready;
  endfunction
  function automatic logic we_of(input bit sel);
    return sel ? b_we : a_we;
  endfunction
  function automatic logic [7:0] addr_of(input bit sel);
    return sel ? {6'd0, b_addr} : a_addr;
  endfunction
  function automatic logic [31:0] wdata_of(input bit sel);
    return sel ? b_wdata : a_wdata;
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_next_addr = 8'd0;
    sb.delete();
  endtask

  // Offer one bundle; when exp_wr is set the expected word is queued.
  task automatic send(input bit sel, input logic [2:0] fmt, input logic [4:0] op,
                      input logic [2:0] f3, input logic f7b5, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                      input logic last, input bit exp_wr, input logic [31:0] exp_word);
    int t = 0;
    while (!rdy_of(sel) && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (rdy_of(sel) !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready: in_ready=%b required 1 within 20 cycles", rdy_of(sel));
    end else begin
      if (exp_wr) begin
        sb.push_back('{addr: exp_next_addr, data: exp_word});
        exp_next_addr = exp_next_addr + 8'd1;
      end
      in_fmt = fmt; in_op = op; in_funct3 = f3; in_f7b5 = f7b5;
      in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Wait for a write request, compare against the scoreboard, hold, then ack.
  task automatic service(input bit sel, input int hold);
    int t = 0;
    exp_t e;
    while (!we_of(sel) && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (we_of(sel) !== 1'b1) begin
      n_fail++;
      $display("FAIL write_timeout: imem_we=%b required 1 within 20 cycles", we_of(sel));
    end else if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_write: addr=%0d data=%h, scoreboard empty", addr_of(sel), wdata_of(sel));
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (addr_of(sel) !== e.addr) begin
        n_fail++;
        $display("FAIL write_addr: got %0d expected %0d", addr_of(sel), e.addr);
      end
      n_checks++;
      if (wdata_of(sel) !== e.data) begin
        n_fail++;
        $display("FAIL write_data: got %h expected %h", wdata_of(sel), e.data);
      end
      for (int i = 1; i < hold; i++) begin
        @(negedge clk);
        n_checks++;
        if (we_of(sel) !== 1'b1 || addr_of(sel) !== e.addr || wdata_of(sel) !== e.data) begin
          n_fail++;
          $display("FAIL write_hold: we=%b addr=%0d data=%h expected 1/%0d/%h",
                   we_of(sel), addr_of(sel), wdata_of(sel), e.addr, e.data);
        end
      end
      if (sel) b_ack_drv = 1'b1; else a_ack_drv = 1'b1;
      @(negedge clk);
      b_ack_drv = 1'b0;
      a_ack_drv = 1'b0;
      n_checks++;
      if (we_of(sel) !== 1'b0) begin
        n_fail++;
        $display("FAIL we_after_ack: got %b expected 0", we_of(sel));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({a_ready, a_we, a_done, a_err} !== 4'b0000 || a_addr !== 8'd0 ||
        a_wdata !== 32'h0 || a_count !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_state: rdy/we/done/err=%b%b%b%b addr=%0d wdata=%h count=%0d expected all 0",
               a_ready, a_we, a_done, a_err, a_addr, a_wdata, a_count);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ready: got %b expected 0 before start", a_ready);
    end
  endtask

  task automatic test_add();
    do_start();
    n_checks++;
    if (a_ready !== 1'b1 || a_count !== 9'd0) begin
      n_fail++;
      $display("FAIL start_state: ready=%b count=%0d expected 1/0", a_ready, a_count);
    end
    send(1'b0, 3'b101, 5'b01100, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'h002081B3);
    service(1'b0, 2);
    n_checks++;
    if (a_count !== 9'd1 || a_done !== 1'b0) begin
      n_fail++;
      $display("FAIL add_count: count=%0d done=%b expected 1/0", a_count, a_done);
    end
  endtask

  task automatic test_back_to_back();
    do_start();
    send(1'b0, 3'b101, 5'b01100, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'h402081B3);
    service(1'b0, 1);
    send(1'b0, 3'b000, 5'b00100, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 1'b1, 32'h00500093);
    service(1'b0, 1);
    n_checks++;
    if (a_done !== 1'b1 || a_ready !== 1'b0 || a_count !== 9'd2) begin
      n_fail++;
      $display("FAIL done_state: done=%b ready=%b count=%0d expected 1/0/2", a_done, a_ready, a_count);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (a_we !== 1'b0 || a_done !== 1'b1) begin
        n_fail++;
        $display("FAIL done_ignores_input: we=%b done=%b expected 0/1", a_we, a_done);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_formats();
    do_start();
    send(1'b0, 3'b010, 5'b11000, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 1'b1, 32'h00208463);
    service(1'b0, 1);
    send(1'b0, 3'b100, 5'b11011, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 1'b1, 32'h001000EF);
    service(1'b0, 1);
    send(1'b0, 3'b011, 5'b01101, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0, 1'b1, 32'h123452B7);
    service(1'b0, 1);
    send(1'b0, 3'b001, 5'b01000, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd12, 1'b0, 1'b1, 32'h0020A623);
    service(1'b0, 1);
    send(1'b0, 3'b000, 5'b00100, 3'b101, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3, 1'b0, 1'b1, 32'h4030D093);
    service(1'b0, 1);
    send(1'b0, 3'b010, 5'b11000, 3'b001, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0, 1'b1, 32'hFE209EE3);
    service(1'b0, 3);
    n_checks++;
    if (a_count !== 9'd6 || a_addr !== 8'd6) begin
      n_fail++;
      $display("FAIL formats_count: count=%0d addr=%0d expected 6/6", a_count, a_addr);
    end
  endtask

  task automatic check_enc_err(input string name);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (a_err !== 1'b1 || a_ready !== 1'b0 || a_we !== 1'b0) begin
        n_fail++;
        $display("FAIL %s: err=%b ready=%b we=%b expected 1/0/0", name, a_err, a_ready, a_we);
      end
    end
  endtask

  task automatic test_enc_err();
    do_start();
    send(1'b0, 3'b010, 5'b11000, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd7, 1'b0, 1'b0, 32'h0);
    check_enc_err("odd_branch_err");
    do_start();
    n_checks++;
    if (a_err !== 1'b0 || a_ready !== 1'b1 || a_count !== 9'd0) begin
      n_fail++;
      $display("FAIL restart_after_err: err=%b ready=%b count=%0d expected 0/1/0", a_err, a_ready, a_count);
    end
    send(1'b0, 3'b110, 5'b01100, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 1'b0, 32'h0);
    check_enc_err("bad_fmt_err");
    do_start();
    send(1'b0, 3'b100, 5'b11011, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd9, 1'b0, 1'b0, 32'h0);
    check_enc_err("odd_jal_err");
  endtask

  task automatic test_overflow();
    a_auto = 1'b1;
    b_auto = 1'b0;
    do_start();
    for (int k = 0; k < 4; k++) begin
      send(1'b1, 3'b000, 5'b00100, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'(k), 1'b0, 1'b1,
           32'h00000093 | (32'(k) << 20));
      service(1'b1, 1);
    end
    n_checks++;
    if (b_err !== 1'b1 || b_ready !== 1'b0 || b_count !== 3'd4 || b_done !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_state: err=%b ready=%b count=%0d done=%b expected 1/0/4/0",
               b_err, b_ready, b_count, b_done);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (b_we !== 1'b0 || b_count !== 3'd4) begin
        n_fail++;
        $display("FAIL overflow_no_write: we=%b count=%0d expected 0/4", b_we, b_count);
      end
    end
    in_valid = 1'b0;
    a_auto = 1'b0;
    b_auto = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rst_mid_write();
    do_start();
    send(1'b0, 3'b101, 5'b01100, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'h002081B3);
    service(1'b0, 1);
    send(1'b0, 3'b101, 5'b01100, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (a_we !== 1'b1 || a_count !== 9'd1) begin
      n_fail++;
      $display("FAIL pre_rst_write: we=%b count=%0d expected 1/1", a_we, a_count);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (a_we !== 1'b0 || a_count !== 9'd0 || a_done !== 1'b0 || a_err !== 1'b0 ||
        a_ready !== 1'b0 || a_addr !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_mid_write: we=%b count=%0d done=%b err=%b ready=%b addr=%0d expected 0/0/0/0/0/0",
               a_we, a_count, a_done, a_err, a_ready, a_addr);
    end
    a_ack_drv = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (a_we !== 1'b0 || a_count !== 9'd0 || a_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stray_ack_idle: we=%b count=%0d ready=%b expected 0/0/0", a_we, a_count, a_ready);
      end
    end
    a_ack_drv = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_fmt = 3'b000; in_op = 5'b00000;
    in_funct3 = 3'b000; in_f7b5 = 1'b0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_imm = 32'd0; in_last = 1'b0; a_ack_drv = 1'b0; b_ack_drv = 1'b0;
    a_auto = 1'b0; b_auto = 1'b1; exp_next_addr = 8'd0;
    @(negedge clk);
    test_reset();
    test_add();
    test_back_to_back();
    test_formats();
    test_enc_err();
    test_overflow();
    test_rst_mid_write();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
